// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-input valid/ready stream multiplexer with packet-level
// arbitration. One channel is granted per packet (round-robin or fixed
// priority) and beats go through a single registered output slice.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | between packets; arbitrate among valid channels each cycle
// LOCKED | mid-packet; only lock_ch may be granted until its last beat
module stream_arb_mux #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 4,
    parameter int MODE   = 0,
    localparam int SEL_BITS = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in_data [INPUTS],
    input  logic [INPUTS-1:0]   in_valid,
    input  logic [INPUTS-1:0]   in_last,
    output logic [INPUTS-1:0]   in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic [SEL_BITS-1:0] out_sel,
    input  logic                out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [SEL_BITS-1:0] rr_ptr;
    logic [SEL_BITS-1:0] lock_ch;

    logic                slot_free;
    logic [SEL_BITS-1:0] winner;
    logic                winner_ok;
    logic [SEL_BITS-1:0] grant;
    logic                grant_ok;
    logic [WIDTH-1:0]    sel_data;
    logic                sel_last;
    logic                accept;
    logic [SEL_BITS-1:0] next_ptr;

    // The output register can take a new beat if empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;

    // Arbitration: first valid channel from rr_ptr upward with wrap, or from 0.
    always_comb begin
        int idx;
        winner    = '0;
        winner_ok = 1'b0;
        idx       = 0;
        for (int i = 0; i < INPUTS; i++) begin
            idx = (MODE == 1) ? i : int'(rr_ptr) + i;
            if (idx >= INPUTS) begin
                idx = idx - INPUTS;
            end
            if (!winner_ok && in_valid[idx]) begin
                winner_ok = 1'b1;
                winner    = SEL_BITS'(idx);
            end
        end
    end

    // A locked channel is granted regardless of its own valid, so its ready
    // never loops back through its valid.
    always_comb begin
        grant    = winner;
        grant_ok = winner_ok;
        if (state == LOCKED) begin
            grant    = lock_ch;
            grant_ok = 1'b1;
        end
    end

    // One-hot ready to the granted channel only when the slot can take a beat.
    always_comb begin
        in_ready = '0;
        if (!rst && slot_free) begin
            in_ready = INPUTS'(grant_ok) << grant;
        end
    end

    // Select the granted channel's beat without indexing past the array.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant == SEL_BITS'(i)) begin
                sel_data = in_data[i];
                sel_last = in_last[i];
            end
        end
    end

    assign accept   = |(in_valid & in_ready);
    assign next_ptr = (grant == SEL_BITS'(INPUTS - 1)) ? '0 : grant + SEL_BITS'(1);

    // Packet FSM, round-robin pointer and the registered output slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_sel   <= grant;
                if (sel_last) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end else begin
                    state   <= LOCKED;
                    lock_ch <= grant;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: three instances (round-robin x4, fixed priority
// x4, single input) share one stimulus stream; a packet-level reference
// model per instance predicts grants and output beats every cycle.
module tb_stream_arb_mux;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         out_ready;
    logic [W-1:0] in_data [N];
    logic [W-1:0] in_data2 [1];
    logic [N-1:0] in_valid;
    logic [N-1:0] in_last;

    logic [N-1:0] rdy0, rdy1;
    logic [0:0]   rdy2;
    logic [W-1:0] od0, od1, od2;
    logic         ov0, ov1, ov2, ol0, ol1, ol2;
    logic [1:0]   os0, os1;
    logic [0:0]   os2;

    assign in_data2[0] = in_data[0];

    always #5 clk = ~clk;

    stream_arb_mux #(.WIDTH(W), .INPUTS(N), .MODE(0)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy0), .out_data(od0), .out_valid(ov0),
        .out_last(ol0), .out_sel(os0), .out_ready(out_ready));

    stream_arb_mux #(.WIDTH(W), .INPUTS(N), .MODE(1)) u_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy1), .out_data(od1), .out_valid(ov1),
        .out_last(ol1), .out_sel(os1), .out_ready(out_ready));

    stream_arb_mux #(.WIDTH(W), .INPUTS(1), .MODE(0)) u_one (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid[0:0]),
        .in_last(in_last[0:0]), .in_ready(rdy2), .out_data(od2), .out_valid(ov2),
        .out_last(ol2), .out_sel(os2), .out_ready(out_ready));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state per instance
    int nn [3] = '{4, 4, 1};
    int md [3] = '{0, 1, 0};
    int e_ov [3], e_od [3], e_ol [3], e_os [3];
    int lk [3], lch [3], ptr [3];
    int gk [3];
    bit armed = 1'b0;

    // producer queues: {last, data}
    logic [8:0] qmem [N][64];
    int  qh [N], qt [N];
    bit  fromq [N];
    logic [3:0] always_mask = 4'b0;
    bit  rand_mode = 1'b0;

    task automatic push(input int c, input bit l, input int d);
        qmem[c][qt[c] % 64] = {l, d[7:0]};
        qt[c]++;
    endtask

    task automatic clear_q();
        for (int c = 0; c < N; c++) qh[c] = qt[c];
    endtask

    function automatic int valid_mask(int k);
        return (k == 2) ? int'(in_valid[0]) : int'(in_valid);
    endfunction

    // Which channel the instance should grant this cycle, or -1.
    function automatic int exp_grant(int k);
        int vm = valid_mask(k);
        if (rst) return -1;
        if (e_ov[k] != 0 && !out_ready) return -1;
        if (lk[k] != 0) return lch[k];
        for (int j = 0; j < nn[k]; j++) begin
            int c = (md[k] == 1) ? j : (ptr[k] + j) % nn[k];
            if (((vm >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic get_obs(input int k, output int r, output int v, output int d,
                           output int l, output int s);
        case (k)
            0: begin r = int'(rdy0); v = int'(ov0); d = int'(od0); l = int'(ol0); s = int'(os0); end
            1: begin r = int'(rdy1); v = int'(ov1); d = int'(od1); l = int'(ol1); s = int'(os1); end
            default: begin r = int'(rdy2); v = int'(ov2); d = int'(od2); l = int'(ol2); s = int'(os2); end
        endcase
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < N; c++) begin
            fromq[c] = 1'b0;
            if (qt[c] != qh[c]) begin
                in_valid[c] = 1'b1;
                {in_last[c], in_data[c]} = qmem[c][qh[c] % 64];
                fromq[c] = 1'b1;
            end else if (always_mask[c]) begin
                in_valid[c] = 1'b1;
                in_last[c]  = 1'b1;
                in_data[c]  = W'(8'h10 + c);
            end else if (rand_mode) begin
                in_valid[c] = 1'($urandom);
                in_last[c]  = 1'($urandom);
                in_data[c]  = W'($urandom);
            end else begin
                in_valid[c] = 1'b0;
                in_last[c]  = 1'b0;
                in_data[c]  = '0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic ordy);
        int ro, vo, dob, lo, so;
        logic [N-1:0] acc0;
        @(negedge clk);
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                get_obs(k, ro, vo, dob, lo, so);
                check_eq($sformatf("out_valid[%0d]", k), vo, e_ov[k]);
                check_eq($sformatf("out_data[%0d]", k), dob, e_od[k]);
                check_eq($sformatf("out_last[%0d]", k), lo, e_ol[k]);
                check_eq($sformatf("out_sel[%0d]", k), so, e_os[k]);
            end
        end
        rst = r;
        out_ready = ordy;
        drive_inputs();
        #1;
        for (int k = 0; k < 3; k++) begin
            gk[k] = exp_grant(k);
            get_obs(k, ro, vo, dob, lo, so);
            check_eq($sformatf("in_ready[%0d]", k), ro, (gk[k] >= 0) ? (1 << gk[k]) : 0);
        end
        acc0 = in_valid & rdy0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                e_ov[k] = 0; e_od[k] = 0; e_ol[k] = 0; e_os[k] = 0;
                lk[k] = 0; lch[k] = 0; ptr[k] = 0;
            end else if (gk[k] >= 0 && ((valid_mask(k) >> gk[k]) & 1) != 0) begin
                e_ov[k] = 1;
                e_od[k] = int'(in_data[gk[k]]);
                e_ol[k] = int'(in_last[gk[k]]);
                e_os[k] = gk[k];
                if (e_ol[k] != 0) begin
                    lk[k]  = 0;
                    ptr[k] = (gk[k] + 1) % nn[k];
                end else begin
                    lk[k]  = 1;
                    lch[k] = gk[k];
                end
            end else if (out_ready) begin
                e_ov[k] = 0;
            end
        end
        if (rst) armed = 1'b1;
        for (int c = 0; c < N; c++) begin
            if (fromq[c] && acc0[c]) qh[c]++;
        end
    endtask

    task automatic run(input int cycles, input logic ordy);
        for (int i = 0; i < cycles; i++) cycle(1'b0, ordy);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            qh[c] = 0; qt[c] = 0; in_data[c] = '0;
        end
        in_valid = '0;
        in_last  = '0;
        for (int k = 0; k < 3; k++) begin
            e_ov[k] = 0; e_od[k] = 0; e_ol[k] = 0; e_os[k] = 0;
            lk[k] = 0; lch[k] = 0; ptr[k] = 0; gk[k] = -1;
        end

        // reset with every channel valid, then round-robin single beats
        always_mask = 4'b1111;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        run(12, 1'b1);

        // packet lock: ch2 three-beat packet, ch0 arrives while locked
        always_mask = 4'b0000;
        run(2, 1'b1);
        clear_q();
        push(2, 1'b0, 8'hA0);
        push(2, 1'b0, 8'hA1);
        push(2, 1'b1, 8'hA2);
        cycle(1'b0, 1'b1);
        push(0, 1'b1, 8'h05);
        run(6, 1'b1);

        // backpressure in the middle of multi-beat packets
        clear_q();
        for (int c = 0; c < N; c++) begin
            for (int b = 0; b < 3; b++) push(c, b == 2, c * 16 + b);
        end
        run(2, 1'b1);
        run(3, 1'b0);
        run(15, 1'b1);

        // fixed-priority contention between ch1 and ch3
        clear_q();
        always_mask = 4'b1010;
        run(10, 1'b1);
        always_mask = 4'b0000;
        run(2, 1'b1);

        // reset during beat 2 of a four-beat ch1 packet
        clear_q();
        for (int b = 0; b < 4; b++) push(1, b == 3, 8'hC0 + b);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        push(0, 1'b1, 8'h33);
        cycle(1'b1, 1'b1);
        run(8, 1'b1);

        // randomized traffic, backpressure and occasional reset
        clear_q();
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
